// File: rtl/nios2_system_led_pio.sv
// LED output PIO for the Nios II system: DATA register with set/clear aliases,
// per-bit blink mask and a shared blink phase from a reloadable down-counter.
module nios2_system_led_pio #(
    parameter int DATA_WIDTH   = 10,
    parameter int RESET_VALUE  = 0,
    parameter int PERIOD_WIDTH = 24,
    parameter int PERIOD_RESET = 12500000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [DATA_WIDTH-1:0]   DATA_RST   = DATA_WIDTH'(RESET_VALUE);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_RST = PERIOD_WIDTH'(PERIOD_RESET);

    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   blink_r;
    logic [PERIOD_WIDTH-1:0] period_r;
    logic [PERIOD_WIDTH-1:0] counter_r;
    logic                    phase_r;

    logic                    wr_s;
    logic                    period_zero_s;
    logic [DATA_WIDTH-1:0]   wd_data_s;
    logic [PERIOD_WIDTH-1:0] wd_period_s;
    logic [31:0]             rd_mux_s;

    assign wr_s          = chipselect & ~write_n;
    assign period_zero_s = (period_r == {PERIOD_WIDTH{1'b0}});
    assign wd_data_s     = writedata[DATA_WIDTH-1:0];
    assign wd_period_s   = writedata[PERIOD_WIDTH-1:0];

    // DATA and BLINK registers, including the atomic set/clear aliases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r  <= DATA_RST;
            blink_r <= {DATA_WIDTH{1'b0}};
        end else if (wr_s) begin
            case (address)
                3'd0:    data_r  <= wd_data_s;
                3'd1:    blink_r <= wd_data_s;
                3'd4:    data_r  <= data_r | wd_data_s;
                3'd5:    data_r  <= data_r & ~wd_data_s;
                default: ;
            endcase
        end
    end

    // Blink engine; a PERIOD write restarts the half-period with phase high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_r  <= PERIOD_RST;
            counter_r <= PERIOD_RST;
            phase_r   <= 1'b1;
        end else if (wr_s && (address == 3'd2)) begin
            period_r  <= wd_period_s;
            counter_r <= wd_period_s;
            phase_r   <= 1'b1;
        end else if (period_zero_s) begin
            counter_r <= {PERIOD_WIDTH{1'b0}};
            phase_r   <= 1'b1;
        end else if (counter_r == {PERIOD_WIDTH{1'b0}}) begin
            counter_r <= period_r;
            phase_r   <= ~phase_r;
        end else begin
            counter_r <= counter_r - {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Read address mux, zero-extended to the bus width
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            3'd0:    rd_mux_s = 32'(data_r);
            3'd1:    rd_mux_s = 32'(blink_r);
            3'd2:    rd_mux_s = 32'(period_r);
            3'd3:    rd_mux_s = {30'd0, period_zero_s, phase_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Read data register, one cycle behind the address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            readdata <= rd_mux_s;
        end
    end

    // Flop-only output decode keeps bus inputs off the LED path
    assign out_port = data_r & (~blink_r | {DATA_WIDTH{phase_r}});

endmodule

// File: tb/tb_nios2_system_led_pio.sv
// Directed bench for nios2_system_led_pio: register access, set/clear aliases,
// blink timing, PERIOD-write priority and asynchronous reset.
module tb_nios2_system_led_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int checks_r   = 0;
    int failures_r = 0;

    nios2_system_led_pio #(
        .DATA_WIDTH   (10),
        .RESET_VALUE  (0),
        .PERIOD_WIDTH (24),
        .PERIOD_RESET (7)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        address = addr;
        @(negedge clk);
        check(tag, readdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset values
        bus_read(3'd0, 32'h000, "rst_data");
        bus_read(3'd1, 32'h000, "rst_blink");
        bus_read(3'd2, 32'd7,   "rst_period");
        bus_read(3'd3, 32'h001, "rst_status");
        check("rst_out", 32'(out_port), 32'h000);

        // DATA write with upper-bit masking, then set/clear aliases
        bus_write(3'd0, 32'hFFFF_F3A5);
        check("data_out", 32'(out_port), 32'h3A5);
        bus_read(3'd0, 32'h3A5, "data_rd");
        bus_write(3'd4, 32'h0000_000A);
        check("outset", 32'(out_port), 32'h3AF);
        bus_write(3'd5, 32'h0000_0300);
        check("outclear", 32'(out_port), 32'h0AF);
        bus_read(3'd4, 32'h000, "rd_off4");

        // Reserved offset and deselected write have no effect
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, 32'h000, "rd_off6");
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'd0;
        @(negedge clk);
        write_n = 1'b1;
        check("cs_low", 32'(out_port), 32'h0AF);

        // Blink with PERIOD=3: 4 cycles high, 4 cycles low
        bus_write(3'd0, 32'h3FF);
        bus_write(3'd1, 32'h00F);
        bus_write(3'd2, 32'd3);
        address = 3'd3;
        for (int i = 0; i < 16; i++) begin
            check("blink3_out", 32'(out_port), (((i / 4) % 2) == 0) ? 32'h3FF : 32'h3F0);
            if (i > 0)
                check("blink3_status", readdata, ((((i - 1) / 4) % 2) == 0) ? 32'h1 : 32'h0);
            @(negedge clk);
        end

        // PERIOD=0 freezes phase high
        bus_write(3'd2, 32'd0);
        address = 3'd3;
        for (int i = 0; i < 8; i++) begin
            check("freeze_out", 32'(out_port), 32'h3FF);
            if (i > 0)
                check("freeze_status", readdata, 32'h3);
            @(negedge clk);
        end

        // PERIOD=1: toggles every 2 cycles starting high
        bus_write(3'd2, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("blink1_out", 32'(out_port), (((i / 2) % 2) == 0) ? 32'h3FF : 32'h3F0);
            @(negedge clk);
        end

        // PERIOD=5 written on the counter-zero edge wins over the toggle
        bus_write(3'd2, 32'd1);
        bus_write(3'd2, 32'd5);
        for (int i = 0; i < 8; i++) begin
            check("collide_out", 32'(out_port), (i < 6) ? 32'h3FF : 32'h3F0);
            @(negedge clk);
        end

        // Asynchronous reset mid-blink
        bus_write(3'd0, 32'h155);
        address = 3'd0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_rd", readdata, 32'h155);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out_port), 32'h000);
        check("async_rst_rd", readdata, 32'h000);
        address = 3'd3;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("post_rst_phase", readdata, ((k - 1) < 8) ? 32'h1 : 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
